// File: rtl/nios2_mult_seq.sv
// nios2_mult_seq: multi-cycle DATA_W x DATA_W integer multiplier for the
// Nios II custom execute path. One HALF_W x HALF_W multiplier is reused for
// the four partial products. The result is either the low word (MUL) or the
// high word (MULXUU/MULXSU/MULXSS) of the 2*DATA_W product. Operands arrive
// and results leave through valid/ready handshakes.
//
// Build option: define NIOS2_MULT_SIGNED_EN to enable the signed high-word
// correction for MULXSU/MULXSS. Without it, op[1] carries no sign meaning and
// every high-word op returns the unsigned (MULXUU) result. Latency is the same
// in both builds.
module nios2_mult_seq #(
    parameter int DATA_W = 32,
    parameter int HALF_W = DATA_W / 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic [1:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PP   = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Latched operation; only meaningful after an accept.
    logic [DATA_W-1:0]   a_p0, b_p0;
    logic [1:0]          op_p0;

    logic [2*DATA_W-1:0] acc;
    logic [1:0]          pp_idx;

    logic                accept;
    logic                is_mul;
    logic                pp_last;
    logic [HALF_W-1:0]   mul_a, mul_b;
    logic [DATA_W-1:0]   pp_prod;
    logic [2*DATA_W-1:0] pp_term;
    logic [DATA_W-1:0]   acc_hi, acc_lo;
    logic [DATA_W-1:0]   hi_word;
    logic [DATA_W-1:0]   res_nxt;

`ifdef NIOS2_MULT_SIGNED_EN
    // Signed high word from the unsigned one: a negative A contributes
    // -B * 2^DATA_W to the product, a negative B contributes -A * 2^DATA_W.
    function automatic logic [DATA_W-1:0] correct_hi(
        input logic [DATA_W-1:0] hi_u,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [1:0]        opc
    );
        logic a_neg, b_neg;
        a_neg = opc[1] & a[DATA_W-1];
        b_neg = (opc == 2'b11) & b[DATA_W-1];
        return hi_u - (a_neg ? b : '0) - (b_neg ? a : '0);
    endfunction
`endif

    assign accept  = (state == IDLE) & in_valid;
    assign is_mul  = (op_p0 == 2'b00);
    // MUL stops after HL: HH only touches bits at or above DATA_W.
    assign pp_last = (pp_idx == 2'd3) | (is_mul & (pp_idx == 2'd2));

    assign acc_lo = acc[DATA_W-1:0];
    assign acc_hi = acc[2*DATA_W-1:DATA_W];

`ifdef NIOS2_MULT_SIGNED_EN
    assign hi_word = correct_hi(acc_hi, a_p0, b_p0, op_p0);
`else
    assign hi_word = acc_hi;
`endif

    assign res_nxt = is_mul ? acc_lo : hi_word;
    assign pp_prod = DATA_W'(mul_a) * DATA_W'(mul_b);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = PP;
            PP:      if (pp_last)   state_nxt = CORR;
            CORR:                   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Select the half-word pair for this step and align its product.
    always_comb begin
        mul_a   = '0;
        mul_b   = '0;
        pp_term = '0;
        case (pp_idx)
            2'd0: begin
                mul_a   = a_p0[HALF_W-1:0];
                mul_b   = b_p0[HALF_W-1:0];
                pp_term = {{DATA_W{1'b0}}, pp_prod};
            end
            2'd1: begin
                mul_a   = a_p0[HALF_W-1:0];
                mul_b   = b_p0[DATA_W-1:HALF_W];
                pp_term = {{HALF_W{1'b0}}, pp_prod, {HALF_W{1'b0}}};
            end
            2'd2: begin
                mul_a   = a_p0[DATA_W-1:HALF_W];
                mul_b   = b_p0[HALF_W-1:0];
                pp_term = {{HALF_W{1'b0}}, pp_prod, {HALF_W{1'b0}}};
            end
            default: begin
                mul_a   = a_p0[DATA_W-1:HALF_W];
                mul_b   = b_p0[DATA_W-1:HALF_W];
                pp_term = {pp_prod, {DATA_W{1'b0}}};
            end
        endcase
    end

    // Operand capture on accept; never sampled outside IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0  <= src1;
            b_p0  <= src2;
            op_p0 <= op;
        end
    end

    // Accumulate one partial product per PP cycle, wrapping at 2*DATA_W bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc    <= '0;
            pp_idx <= 2'd0;
        end else if (accept) begin
            acc    <= '0;
            pp_idx <= 2'd0;
        end else if (state == PP) begin
            acc    <= acc + pp_term;
            pp_idx <= pp_idx + 2'd1;
        end
    end

    // Registered handshake/status outputs and result word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
        end else begin
            in_ready <= (state_nxt == IDLE);
            busy     <= (state_nxt != IDLE);
            if (state == CORR) begin
                result    <= res_nxt;
                out_valid <= 1'b1;
            end else if ((state == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nios2_mult_seq.sv
// Self-checking bench for nios2_mult_seq: directed cases plus randomized
// operations on a 32-bit instance and a 16-bit instance, compared against a
// wide-integer reference model.
module tb_nios2_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] src1, src2, result;
    logic [1:0]  op;

    logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16, busy_16;
    logic [15:0] src1_16, src2_16, result_16;
    logic [1:0]  op_16;

    int checks = 0;
    int errors = 0;

    nios2_mult_seq #(.DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .op(op),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    nios2_mult_seq #(.DATA_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid_16), .in_ready(in_ready_16),
        .src1(src1_16), .src2(src2_16), .op(op_16),
        .out_valid(out_valid_16), .out_ready(out_ready_16),
        .result(result_16), .busy(busy_16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: true mathematical product of the (optionally signed) operands.
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] opc, input int w);
        logic signed [129:0] sa, sb, full, sh;
        logic [63:0] mask;
        logic sgn_a, sgn_b;
        mask = (64'd1 << w) - 64'd1;
        sa = $signed({66'd0, a & mask});
        sb = $signed({66'd0, b & mask});
`ifdef NIOS2_MULT_SIGNED_EN
        sgn_a = opc[1];
        sgn_b = (opc == 2'b11);
`else
        sgn_a = 1'b0;
        sgn_b = 1'b0;
`endif
        if (sgn_a && a[w-1]) sa = sa - (130'sd1 <<< w);
        if (sgn_b && b[w-1]) sb = sb - (130'sd1 <<< w);
        full = sa * sb;
        sh = (opc == 2'b00) ? full : (full >>> w);
        return sh[63:0] & mask;
    endfunction

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
        @(negedge clk);
        src1 = a; src2 = b; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accept busy/in_ready", {busy, in_ready}, 2'b10);
    endtask

    task automatic finish32(input int exp_lat, input logic [31:0] exp_res,
                            input bit hold_ready, input string tag);
        int lat = 0;
        if (hold_ready) out_ready = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, result, exp_res);
        if (!hold_ready) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, " release"}, {out_valid, in_ready, busy}, 3'b010);
        out_ready = 1'b0;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o,
                         input int exp_lat, input logic [15:0] exp_res, input string tag);
        int lat = 0;
        @(negedge clk);
        src1_16 = a; src2_16 = b; op_16 = o; in_valid_16 = 1'b1;
        @(posedge clk); #1;
        in_valid_16 = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid_16) break;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, result_16, exp_res);
        @(negedge clk);
        out_ready_16 = 1'b1;
        @(posedge clk); #1;
        chk({tag, " release"}, {out_valid_16, in_ready_16, busy_16}, 3'b010);
        out_ready_16 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        bit          rh;
        bit          saw_valid;

        reset_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; src1 = '0; src2 = '0; op = 2'b00;
        in_valid_16 = 1'b0; out_ready_16 = 1'b0; src1_16 = '0; src2_16 = '0; op_16 = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset status", {in_ready, out_valid, busy}, 3'b100);
        chk("reset result", result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Low word and unsigned high word.
        start32(32'h0001_0003, 32'h0002_0005, 2'b00);
        finish32(4, 32'h000B_000F, 1'b0, "mul");
        start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        finish32(5, 32'hFFFF_FFFE, 1'b0, "mulxuu");

        // Signed high-word ops.
        start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
`ifdef NIOS2_MULT_SIGNED_EN
        finish32(5, 32'h0000_0000, 1'b1, "mulxss -1*-1");
`else
        finish32(5, 32'hFFFF_FFFE, 1'b1, "mulxss -1*-1");
`endif
        start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10);
`ifdef NIOS2_MULT_SIGNED_EN
        finish32(5, 32'hFFFF_FFFF, 1'b0, "mulxsu -1*max");
`else
        finish32(5, 32'hFFFF_FFFE, 1'b0, "mulxsu -1*max");
`endif
        start32(32'h8000_0000, 32'h8000_0000, 2'b11);
        finish32(5, 32'h4000_0000, 1'b0, "mulxss min*min");

        // Backpressure: result held, new requests ignored.
        start32(32'd3, 32'd5, 2'b00);
        begin
            int lat = 0;
            repeat (20) begin
                @(posedge clk); #1;
                lat++;
                if (out_valid) break;
            end
            chk("bp latency", 64'(lat), 64'd4);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i == 3);
            if (i == 3) begin
                src1 = 32'd9; src2 = 32'd9; op = 2'b00;
            end
            @(posedge clk); #1;
            chk("bp hold status", {out_valid, in_ready, busy}, 3'b101);
            chk("bp hold result", result, 32'd15);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release", {out_valid, in_ready, busy}, 3'b010);
        out_ready = 1'b0;
        start32(32'h11, 32'h3, 2'b00);
        finish32(4, 32'h33, 1'b0, "after bp");

        // Reset in the middle of PP.
        start32(32'h1234, 32'h5678, 2'b01);
        @(posedge clk);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("midreset status", {out_valid, in_ready, busy}, 3'b010);
        chk("midreset result", result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) saw_valid = 1'b1;
        end
        chk("discarded op never reported", saw_valid, 1'b0);
        start32(32'd7, 32'd6, 2'b00);
        finish32(4, 32'd42, 1'b1, "post-reset mul");

        // Randomized operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 2'($urandom_range(0, 3));
            rh = 1'($urandom_range(0, 1));
            if (i % 5 == 0) ra = {1'b1, ra[30:0]};
            if (i % 7 == 0) rb = {1'b1, rb[30:0]};
            start32(ra, rb, ro);
            finish32((ro == 2'b00) ? 4 : 5, 32'(model({32'd0, ra}, {32'd0, rb}, ro, 32)), rh, "rand32");
        end

        // 16-bit instance.
        run16(16'h8000, 16'h8000, 2'b11, 5, 16'h4000, "w16 mulxss");
        run16(16'hFFFF, 16'h0002, 2'b00, 4, 16'hFFFE, "w16 mul");
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            ro = 2'($urandom_range(0, 3));
            run16(ra[15:0], rb[15:0], ro, (ro == 2'b00) ? 4 : 5,
                  16'(model({48'd0, ra[15:0]}, {48'd0, rb[15:0]}, ro, 16)), "rand16");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
